// File: rtl/debounce_fsm.sv
// ---------------------------------------------------------------------------
// debounce_fsm
//
// Purpose:
//   Turns a raw, possibly bouncing mechanical input into a clean level. The
//   level only changes after STABLE_CYCLES consecutive identical samples that
//   differ from the current level. Any reversal during qualification throws
//   away the partial count; there is no partial credit. The output is meant
//   to drive positive_edge_detector.level, so each physical press produces
//   exactly one tick downstream.
//
// Configuration macro:
//   DEBOUNCE_SYNC_EN - when defined, din passes through a two-flop
//                      synchronizer (sync1 -> sync2) before the FSM sees it.
//                      This adds two cycles of latency and is needed when din
//                      comes straight from a pad. When undefined, din is used
//                      directly and must already be synchronous to clk.
//
// Parameters:
//   STABLE_CYCLES - consecutive identical samples needed before level
//                   changes (1 .. 2^CNT_W-1)
//   CNT_W         - width of the stability counter
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   din   in   raw button/switch input
//   level out  debounced level, decoded from the registered state
//   busy  out  high while a candidate transition is being qualified
// ---------------------------------------------------------------------------
module debounce_fsm #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic busy
);

  // The encoding keeps level in bit 1 and busy as the XOR of both bits, but
  // the output decode below compares full state names for readability.
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    WAIT_HIGH   = 2'b01,
    STABLE_HIGH = 2'b11,
    WAIT_LOW    = 2'b10
  } state_t;

  // With a single required sample the WAIT states are skipped entirely.
  localparam bit SINGLE = (STABLE_CYCLES == 1);

  // The sample that completes a run arrives when cnt already holds N-1, so
  // comparing against N-1 is the same as testing cnt+1 == N without needing
  // an extra counter bit.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             s;

`ifdef DEBOUNCE_SYNC_EN
  logic sync1;
  logic sync2;

  // Two-flop synchronizer: sync1 may go metastable, sync2 gives it a full
  // cycle to resolve before the FSM looks at it. Both clear on reset so a
  // stale high can never leak into the first post-reset qualification.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = din;
`endif

  // State and counter registers. Reset drops any partial count so a full
  // run is needed again after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= STABLE_LOW;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic. The defaults send any unexpected encoding back to
  // STABLE_LOW with a cleared counter, which is also the glitch-rejected
  // return path, so only the "stay" and "advance" cases need to be spelled
  // out.
  always_comb begin
    state_next = STABLE_LOW;
    cnt_next   = '0;

    case (state)
      STABLE_LOW: begin
        if (s) begin
          if (SINGLE) begin
            state_next = STABLE_HIGH;
          end else begin
            state_next = WAIT_HIGH;
            cnt_next   = CNT_W'(1);
          end
        end else begin
          state_next = STABLE_LOW;
        end
      end

      WAIT_HIGH: begin
        if (!s) begin
          state_next = STABLE_LOW;
        end else if (cnt == LAST) begin
          state_next = STABLE_HIGH;
        end else begin
          state_next = WAIT_HIGH;
          cnt_next   = cnt + 1'b1;
        end
      end

      STABLE_HIGH: begin
        if (!s) begin
          if (SINGLE) begin
            state_next = STABLE_LOW;
          end else begin
            state_next = WAIT_LOW;
            cnt_next   = CNT_W'(1);
          end
        end else begin
          state_next = STABLE_HIGH;
        end
      end

      WAIT_LOW: begin
        if (s) begin
          state_next = STABLE_HIGH;
        end else if (cnt == LAST) begin
          state_next = STABLE_LOW;
        end else begin
          state_next = WAIT_LOW;
          cnt_next   = cnt + 1'b1;
        end
      end

      default: begin
        state_next = STABLE_LOW;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs depend only on the registered state, so they cannot glitch on
  // input activity between edges.
  assign level = (state == STABLE_HIGH) || (state == WAIT_LOW);
  assign busy  = (state == WAIT_HIGH)   || (state == WAIT_LOW);

endmodule

// File: tb/tb_debounce_fsm.sv
// ---------------------------------------------------------------------------
// tb_debounce_fsm
//
// Drives two debouncers from the same din: one with STABLE_CYCLES=4 and one
// with STABLE_CYCLES=1. Builds with or without DEBOUNCE_SYNC_EN; SYNC_LAT
// accounts for the synchronizer delay.
//
// The reference model keeps the history of samples the FSM sees and flips
// the level whenever the last N samples all disagree with it; busy is simply
// "the most recent sample disagrees with the current level".
// ---------------------------------------------------------------------------
module tb_debounce_fsm;

`ifdef DEBOUNCE_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int N4 = 4;

  typedef struct {
    logic d;
    logic lvl;
    logic bsy;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic level4, busy4, level1, busy1;

  int errors = 0;
  int checks = 0;

  logic din_pipe[$];
  logic s_hist[$];
  logic m_level[2];
  int   m_n[2];

  vec_t tbl[$];

  debounce_fsm #(.STABLE_CYCLES(4), .CNT_W(4)) dut4 (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .level(level4),
    .busy (busy4)
  );

  debounce_fsm #(.STABLE_CYCLES(1), .CNT_W(4)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .level(level1),
    .busy (busy1)
  );

  always #10 clk = ~clk;

  // Return the model to its post-reset condition.
  function automatic void modelReset();
    din_pipe.delete();
    for (int i = 0; i < SYNC_LAT; i++) din_pipe.push_back(1'b0);
    s_hist.delete();
    m_level[0] = 1'b0;
    m_level[1] = 1'b0;
  endfunction

  function automatic bit lastRunDiffers(input int n, input logic lvl);
    if (s_hist.size() < n) return 1'b0;
    for (int i = 0; i < n; i++)
      if (s_hist[s_hist.size() - 1 - i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  // One rising edge: din enters the delay pipe, the delayed sample is
  // appended to the history, and each level flips if its run is complete.
  function automatic void modelEdge(input logic d);
    logic s;
    din_pipe.push_back(d);
    s = din_pipe.pop_front();
    s_hist.push_back(s);
    if (s_hist.size() > 32) void'(s_hist.pop_front());
    for (int k = 0; k < 2; k++)
      if (lastRunDiffers(m_n[k], m_level[k])) m_level[k] = ~m_level[k];
  endfunction

  function automatic logic modelBusy(input int k);
    if (s_hist.size() == 0) return 1'b0;
    return s_hist[s_hist.size() - 1] != m_level[k];
  endfunction

  task automatic checkOutput(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareModel4();
    checkOutput("n4_level_model", level4, m_level[0]);
    checkOutput("n4_busy_model", busy4, modelBusy(0));
  endtask

  // Drive din on the falling edge, advance the model on the rising edge,
  // then look at the outputs 1 time unit later. The N=1 instance is checked
  // against the model on every step.
  task automatic applyStimulus(input logic d);
    @(negedge clk);
    din = d;
    @(posedge clk);
    if (rst) modelReset();
    else modelEdge(d);
    #1;
    checkOutput("n1_level", level1, m_level[1]);
    checkOutput("n1_busy", busy1, modelBusy(1));
  endtask

  // Assert reset mid-cycle and confirm outputs clear with no clock edge.
  // Called 1 time unit after a rising edge; releases shortly after the
  // following rising edge so no edge goes unmodelled.
  task automatic asyncReset();
    #4;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("async_rst_level4", level4, 1'b0);
    checkOutput("async_rst_busy4", busy4, 1'b0);
    checkOutput("async_rst_level1", level1, 1'b0);
    checkOutput("async_rst_busy1", busy1, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // After reset release with din held high, level must stay low until the
  // edge that completes a full run, counted from the first sampling edge.
  task automatic riseAfterReset();
    for (int i = 1; i <= N4 + SYNC_LAT; i++) begin
      applyStimulus(1'b1);
      checkOutput("post_rst_level", level4, (i == N4 + SYNC_LAT) ? 1'b1 : 1'b0);
      compareModel4();
    end
  endtask

  task automatic addVec(input logic d, input logic l, input logic b);
    vec_t v;
    v.d   = d;
    v.lvl = l;
    v.bsy = b;
    tbl.push_back(v);
  endtask

  initial begin
    m_n[0] = N4;
    m_n[1] = 1;

    // Expected outputs for N=4 as seen without the synchronizer; with it,
    // the same values appear SYNC_LAT edges later.
    addVec(1, 0, 1); addVec(1, 0, 1); addVec(1, 0, 1); addVec(1, 1, 0);
    addVec(1, 1, 0);
    addVec(0, 1, 1); addVec(0, 1, 1); addVec(0, 1, 1); addVec(1, 1, 0);
    addVec(0, 1, 1); addVec(0, 1, 1); addVec(0, 1, 1); addVec(0, 0, 0);
    addVec(1, 0, 1); addVec(1, 0, 1); addVec(0, 0, 0);
    addVec(1, 0, 1); addVec(0, 0, 0); addVec(1, 0, 1); addVec(0, 0, 0);
    addVec(1, 0, 1); addVec(1, 0, 1); addVec(1, 0, 1); addVec(1, 1, 0);

    rst = 1'b1;
    din = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_level4", level4, 1'b0);
    checkOutput("reset_busy4", busy4, 1'b0);
    checkOutput("reset_level1", level1, 1'b0);
    checkOutput("reset_busy1", busy1, 1'b0);
    #1;
    rst = 1'b0;

    for (int i = 0; i < tbl.size() + SYNC_LAT; i++) begin
      applyStimulus((i < tbl.size()) ? tbl[i].d : tbl[tbl.size() - 1].d);
      if (i >= SYNC_LAT) begin
        checkOutput($sformatf("vec%0d_level", i - SYNC_LAT), level4, tbl[i - SYNC_LAT].lvl);
        checkOutput($sformatf("vec%0d_busy", i - SYNC_LAT), busy4, tbl[i - SYNC_LAT].bsy);
      end
    end

    checkOutput("pre_async_level4", level4, 1'b1);
    asyncReset();
    riseAfterReset();

    for (int i = 0; i < N4 + SYNC_LAT; i++) begin
      applyStimulus(1'b0);
      compareModel4();
    end
    checkOutput("fall_level4", level4, 1'b0);

    for (int i = 0; i < SYNC_LAT + 2; i++) applyStimulus(1'b1);
    checkOutput("midwait_busy4", busy4, 1'b1);
    checkOutput("midwait_level4", level4, 1'b0);
    asyncReset();
    riseAfterReset();

    for (int run = 0; run < 120; run++) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 7));
      if ($urandom_range(0, 24) == 0) asyncReset();
      for (int j = 0; j < len; j++) begin
        applyStimulus(v);
        compareModel4();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debounce_fsm.md
Name: debounce_fsm

Overview:
- Conditions a raw, possibly bouncing mechanical input into a clean, glitch-free level.
- Sits directly upstream of positive_edge_detector; its `level` output drives that block's `level` input, so each physical press yields exactly one `tick`.
- Uses a counter-qualified 4-state FSM, with an optional 2-flop input synchronizer.

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical samples required before `level` changes. Legal range is 1 to 2^CNT_W-1.
- CNT_W, 4, width of the stability counter. Must satisfy 2^CNT_W-1 >= STABLE_CYCLES.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  raw input (button/switch). Asynchronous to clk when DEBOUNCE_SYNC_EN is defined.
- level  output  1  debounced level, registered; feeds positive_edge_detector.level.
- busy  output  1  high while a candidate transition is being qualified (WAIT_HIGH or WAIT_LOW state), registered-state decode.

Behaviour:
- Reset (rst=1, asynchronous, effective immediately without a clock edge):
  - state=STABLE_LOW, cnt=0, level=0, busy=0.
  - Synchronizer flops (if present) are cleared to 0.
  - Reset asserted mid-qualification discards the partial count. After release, a full STABLE_CYCLES run is needed again.
- Sample `s`:
  - Equals the synchronizer output when DEBOUNCE_SYNC_EN is defined.
  - Equals `din` directly otherwise.
  - The FSM examines `s` once per rising clk edge.
- States and transitions (N = STABLE_CYCLES):
  - STABLE_LOW (level=0, busy=0):
    - s=1 and N==1: go to STABLE_HIGH.
    - s=1 and N>1: go to WAIT_HIGH, cnt=1.
    - s=0: stay, cnt=0.
  - WAIT_HIGH (level=0, busy=1):
    - s=0: back to STABLE_LOW, cnt=0 (glitch rejected).
    - s=1 and cnt+1==N: go to STABLE_HIGH, cnt=0.
    - s=1 otherwise: stay, cnt=cnt+1.
  - STABLE_HIGH (level=1, busy=0): mirror of STABLE_LOW with s=0 as the trigger, target WAIT_LOW.
  - WAIT_LOW (level=1, busy=1): mirror of WAIT_HIGH; s=1 returns to STABLE_HIGH.
- `level` and `busy` are pure functions of the registered state, so they are glitch-free.
- Latency: `level` changes on the clock edge that samples the N-th consecutive differing `s`.
  - With sync: `din` first sampled at edge A gives `level` update at edge A+N+1.
  - Without sync: `level` update at edge A+N-1.
- Any reversal of `s` during WAIT restarts qualification from the stable state. There is no partial credit.
- cnt never exceeds N-1, so there is no wrap-around.
- Illegal state encodings recover to STABLE_LOW with cnt=0 on the next edge.
- N==1: the WAIT states are unreachable, busy stays 0, and `level` tracks `s` with a 1-edge delay.

Optional Feature:
- Macro: DEBOUNCE_SYNC_EN.
- Defined:
  - Two-flop synchronizer on `din` (sync1, sync2), both asynchronously reset to 0.
  - `s` = sync2.
  - Adds 2 cycles of latency.
  - Required when `din` comes from a pad.
- Undefined:
  - No synchronizer; `s` = din.
  - `din` must already be synchronous to clk.
  - Latency is reduced by 2.

Test Plan (STABLE_CYCLES=4, DEBOUNCE_SYNC_EN defined, clk period 20):
- Reset:
  - Stimulus: rst=1 for 2 cycles with din=1, then assert rst asynchronously mid-cycle while level=1.
  - Response: level=0 and busy=0 immediately, with no clock edge needed. level remains 0 until 5 edges after release, not earlier.
- Clean rise:
  - Stimulus: din 0->1 first sampled at edge A, held.
  - Response: busy=1 from A+2 to A+5; level=1 at A+5; exactly one tick from the downstream edge detector.
- Glitch reject:
  - Stimulus: din=1 for 2 cycles, then 0.
  - Response: level stays 0; busy pulses high for 2 cycles; no tick.
- Bounce then settle:
  - Stimulus: din 1,0,1,0 for one cycle each, then held 1 from edge B.
  - Response: level=1 exactly at B+5; level never toggles during the bounce.
- Clean fall:
  - Stimulus: from level=1, din 1->0 first sampled at edge C and held; then repeat with a 3-cycle low glitch.
  - Response: level=0 at C+5; the 3-cycle glitch leaves level=1.
- Mid-WAIT reset:
  - Stimulus: din held 1; rst pulsed while busy=1 and cnt=2.
  - Response: level=0, busy=0, cnt=0; after release, level=1 only 5 edges after the first post-reset sampling edge.
